// File: rtl/table_mem_if.sv
// Bus bundle for table_mem: the pipeline master request/response signals
// and the host table-load byte port.
interface table_mem_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_width_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        ld_we_i;
    logic [31:0] ld_addr_i;
    logic [7:0]  ld_data_i;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        output ld_we_i, ld_addr_i, ld_data_i,
        input  mem_data_o, mem_ready_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        input  ld_we_i, ld_addr_i, ld_data_i,
        output mem_data_o, mem_ready_o
    );
endinterface

// File: rtl/table_mem.sv
// Byte-addressed table memory with a fixed-latency request/response port
// for the pipeline master and an independent host byte-load port.
// Accesses are 1..4 bytes, little-endian lanes, addresses wrap modulo MEM_BYTES.
// The response cycle (RESP) also accepts a new request, giving one access
// every LATENCY+1 cycles when mem_ce_i is held high.
module table_mem #(
    parameter int MEM_BYTES = 4096,
    parameter int LATENCY   = 2
) (
    input logic        clk,
    input logic        rst,
    table_mem_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    width_q;
    logic [31:0]   data_q;
    logic          ready_q;
    logic [31:0]   rdata_q;

    logic [7:0]    storage [MEM_BYTES];

    logic [AW-1:0] lane_addr [4];
    logic          width_valid;
    logic          commit;
    logic [31:0]   rd_word;
    logic          unused_bits;

    // Address bits above the storage size are intentionally ignored.
    assign unused_bits = ^{bus.mem_addr_i[31:AW], bus.ld_addr_i[31:AW]};

    assign width_valid     = (width_q >= 4'd1) && (width_q <= 4'd4);
    assign commit          = (state == WAIT) && (cnt == 4'd0);
    assign bus.mem_ready_o = ready_q;
    assign bus.mem_data_o  = rdata_q;

    // Per-lane wrapped byte addresses and the gathered read word (zero above width).
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_q + AW'(k);
            if (4'(k) < width_q) begin
                rd_word[8*k +: 8] = storage[lane_addr[k]];
            end
        end
    end

    // Request/response FSM: accept, count down the latency, commit and pulse ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            width_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.mem_ce_i) begin
                        we_q    <= bus.mem_we_i;
                        addr_q  <= bus.mem_addr_i[AW-1:0];
                        width_q <= bus.mem_width_i;
                        data_q  <= bus.mem_data_i;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        ready_q <= 1'b1;
                        rdata_q <= (!we_q && width_valid) ? rd_word : 32'd0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    if (bus.mem_ce_i) begin
                        we_q    <= bus.mem_we_i;
                        addr_q  <= bus.mem_addr_i[AW-1:0];
                        width_q <= bus.mem_width_i;
                        data_q  <= bus.mem_data_i;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Storage writes: host load first, master commit last so it wins a same-byte clash.
    always_ff @(posedge clk) begin
        if (bus.ld_we_i) begin
            storage[bus.ld_addr_i[AW-1:0]] <= bus.ld_data_i;
        end
        if (!rst && commit && we_q && width_valid) begin
            for (int k = 0; k < 4; k++) begin
                if (4'(k) < width_q) begin
                    storage[lane_addr[k]] <= data_q[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_table_mem.sv
// Directed self-checking bench for table_mem (MEM_BYTES 4096, LATENCY 2).
module tb_table_mem;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    table_mem_if bus();

    table_mem #(.MEM_BYTES(4096), .LATENCY(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one host byte load; starts and ends 1 time unit after an edge.
    task automatic host_load(input logic [31:0] addr, input logic [7:0] data);
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = addr;
        bus.ld_data_i = data;
        @(posedge clk); #1;
        bus.ld_we_i   = 1'b0;
    endtask

    // Issue one request, report edges from acceptance to ready, data and ready one cycle later.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] w,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic ready_after);
        logic found;
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_addr_i  = addr;
        bus.mem_width_i = w;
        bus.mem_data_i  = d;
        @(posedge clk); #1;
        bus.mem_ce_i    = 1'b0;
        bus.mem_data_i  = 32'h0BAD_0BAD;
        lat   = -1;
        found = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!found) begin
                @(posedge clk); #1;
                if (bus.mem_ready_o === 1'b1) begin
                    lat   = i;
                    found = 1'b1;
                end
            end
        end
        rd = bus.mem_data_o;
        @(posedge clk); #1;
        ready_after = bus.mem_ready_o;
    endtask

    task automatic test_reset;
        int          lat;
        logic [31:0] rd;
        logic        ra;
        rst           = 1'b1;
        bus.mem_ce_i  = 1'b1;
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = 32'h60;
        bus.ld_data_i = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.mem_ready_o !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_ready got=%b want=0", bus.mem_ready_o);
        end
        total++;
        if (bus.mem_data_o !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_data got=%h want=00000000", bus.mem_data_o);
        end
        bus.ld_we_i  = 1'b0;
        bus.mem_ce_i = 1'b0;
        rst          = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 32'h60, 4'd1, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h0000003C) begin
            bad++; $display("[TB] FAIL load_during_reset got=%h want=0000003c", rd);
        end
    endtask

    task automatic test_host_read;
        int          lat;
        logic [31:0] rd;
        logic        ra;
        host_load(32'h10, 8'h11);
        host_load(32'h11, 8'h22);
        host_load(32'h12, 8'h33);
        host_load(32'h13, 8'h44);
        access(1'b0, 32'h10, 4'd4, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h44332211) begin
            bad++; $display("[TB] FAIL read4_data got=%h want=44332211", rd);
        end
        total++;
        if (lat !== 2) begin
            bad++; $display("[TB] FAIL read4_latency got=%0d want=2", lat);
        end
        total++;
        if (ra !== 1'b0) begin
            bad++; $display("[TB] FAIL ready_one_cycle got=%b want=0", ra);
        end
        access(1'b0, 32'h11, 4'd1, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h00000022) begin
            bad++; $display("[TB] FAIL read1_lanes got=%h want=00000022", rd);
        end
    endtask

    task automatic test_partial_write;
        int          lat;
        logic [31:0] rd;
        logic        ra;
        host_load(32'h20, 8'h99);
        host_load(32'h21, 8'h98);
        host_load(32'h22, 8'h00);
        host_load(32'h23, 8'h00);
        access(1'b1, 32'h20, 4'd2, 32'hAABBCCDD, lat, rd, ra);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("[TB] FAIL write_data_o got=%h want=00000000", rd);
        end
        total++;
        if (lat !== 2) begin
            bad++; $display("[TB] FAIL write_latency got=%0d want=2", lat);
        end
        access(1'b0, 32'h20, 4'd4, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h0000CCDD) begin
            bad++; $display("[TB] FAIL write2_read4 got=%h want=0000ccdd", rd);
        end
    endtask

    task automatic test_wrap;
        int          lat;
        logic [31:0] rd;
        logic        ra;
        host_load(32'hFFE, 8'h01);
        host_load(32'hFFF, 8'h02);
        host_load(32'h000, 8'h03);
        access(1'b0, 32'hFFE, 4'd3, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h00030201) begin
            bad++; $display("[TB] FAIL wrap_read got=%h want=00030201", rd);
        end
        access(1'b1, 32'hFFF, 4'd2, 32'h00005566, lat, rd, ra);
        access(1'b0, 32'hFFE, 4'd3, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h00556601) begin
            bad++; $display("[TB] FAIL wrap_write got=%h want=00556601", rd);
        end
    endtask

    task automatic test_noop;
        int          lat;
        logic [31:0] rd;
        logic        ra;
        access(1'b0, 32'h10, 4'd4, 32'h0, lat, rd, ra);
        access(1'b1, 32'h10, 4'd0, 32'hFFFFFFFF, lat, rd, ra);
        total++;
        if (lat !== 2) begin
            bad++; $display("[TB] FAIL noop_ready_latency got=%0d want=2", lat);
        end
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("[TB] FAIL noop_data_o got=%h want=00000000", rd);
        end
        access(1'b1, 32'h10, 4'd5, 32'hFFFFFFFF, lat, rd, ra);
        access(1'b0, 32'h10, 4'd7, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("[TB] FAIL noop_read_data got=%h want=00000000", rd);
        end
        access(1'b0, 32'h10, 4'd4, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h44332211) begin
            bad++; $display("[TB] FAIL noop_storage got=%h want=44332211", rd);
        end
    endtask

    task automatic test_back_to_back;
        int   pulses;
        logic exp;
        pulses          = 0;
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = 32'h10;
        bus.mem_width_i = 4'd4;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            exp = ((i % 3) == 0);
            total++;
            if (bus.mem_ready_o !== exp) begin
                bad++; $display("[TB] FAIL b2b_ready_cycle%0d got=%b want=%b", i, bus.mem_ready_o, exp);
            end
            if (bus.mem_ready_o === 1'b1) begin
                pulses++;
                total++;
                if (bus.mem_data_o !== 32'h44332211) begin
                    bad++; $display("[TB] FAIL b2b_data got=%h want=44332211", bus.mem_data_o);
                end
            end
        end
        bus.mem_ce_i = 1'b0;
        total++;
        if (pulses !== 6) begin
            bad++; $display("[TB] FAIL b2b_pulse_count got=%0d want=6", pulses);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_collision;
        int          lat;
        logic [31:0] rd;
        logic        ra;
        // Master write vs host load on the commit edge: master value kept.
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_addr_i  = 32'h40;
        bus.mem_width_i = 4'd1;
        bus.mem_data_i  = 32'h000000AB;
        @(posedge clk); #1;
        bus.mem_ce_i = 1'b0;
        @(posedge clk); #1;
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = 32'h40;
        bus.ld_data_i = 8'hCD;
        @(posedge clk); #1;
        bus.ld_we_i = 1'b0;
        total++;
        if (bus.mem_ready_o !== 1'b1) begin
            bad++; $display("[TB] FAIL clash_write_ready got=%b want=1", bus.mem_ready_o);
        end
        @(posedge clk); #1;
        access(1'b0, 32'h40, 4'd1, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h000000AB) begin
            bad++; $display("[TB] FAIL clash_write_value got=%h want=000000ab", rd);
        end
        // Host load on the commit edge of a read: old value returned.
        host_load(32'h50, 8'h11);
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = 32'h50;
        bus.mem_width_i = 4'd1;
        @(posedge clk); #1;
        bus.mem_ce_i = 1'b0;
        @(posedge clk); #1;
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = 32'h50;
        bus.ld_data_i = 8'h77;
        @(posedge clk); #1;
        bus.ld_we_i = 1'b0;
        total++;
        if (bus.mem_data_o !== 32'h00000011) begin
            bad++; $display("[TB] FAIL clash_read_old got=%h want=00000011", bus.mem_data_o);
        end
        @(posedge clk); #1;
        access(1'b0, 32'h50, 4'd1, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h00000077) begin
            bad++; $display("[TB] FAIL clash_read_new got=%h want=00000077", rd);
        end
    endtask

    task automatic test_reset_abort;
        int          lat;
        logic [31:0] rd;
        logic        ra;
        logic        seen;
        host_load(32'h30, 8'h5A);
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_addr_i  = 32'h30;
        bus.mem_width_i = 4'd1;
        bus.mem_data_i  = 32'h000000FF;
        @(posedge clk); #1;
        bus.mem_ce_i = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.mem_ready_o !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_no_ready got=%b want=0", seen);
        end
        access(1'b0, 32'h30, 4'd1, 32'h0, lat, rd, ra);
        total++;
        if (rd !== 32'h0000005A) begin
            bad++; $display("[TB] FAIL abort_storage got=%h want=0000005a", rd);
        end
        total++;
        if (lat !== 2) begin
            bad++; $display("[TB] FAIL abort_next_latency got=%0d want=2", lat);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.mem_ce_i    = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = 32'h0;
        bus.mem_width_i = 4'd0;
        bus.mem_data_i  = 32'h0;
        bus.ld_we_i     = 1'b0;
        bus.ld_addr_i   = 32'h0;
        bus.ld_data_i   = 8'h0;
        test_reset();
        test_host_read();
        test_partial_write();
        test_wrap();
        test_noop();
        test_back_to_back();
        test_collision();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
